ritc_input_align_ctrl: RTL

Per-bit input-delay alignment sequencer for the RITC LVDS data inputs (3 channels × 12 bits = 36 lanes). On request, it steps each lane's IDELAY through every tap and scores each tap against the RITC training pattern. It then loads the centre of the longest passing window into that lane. It sits between the differential input buffers/IDELAY array and the deserializer's pattern checker, and reports per-lane failures to the register block.

---
 rtl/ritc_input_align_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ritc_input_align_ctrl.sv
// Per-lane IDELAY alignment sequencer: sweeps every tap of each lane, scores it
// against the training pattern and loads the centre of the earliest longest passing window.
module ritc_input_align_ctrl #(
  parameter int NBITS  = 36,
  parameter int NTAPS  = 32,
  parameter int SETTLE = 16,
  parameter int NSAMP  = 64,
  localparam int TW    = $clog2(NTAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             match_valid,
  input  logic             match,
  output logic [5:0]       bit_sel,
  output logic [TW-1:0]    delay_tap,
  output logic             delay_load,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] fail_mask
);
  // state    | meaning
  // S_IDLE   | waiting for start
  // S_LOAD   | one-cycle delay load of the tap under test
  // S_SETTLE | let the IDELAY settle, checker verdicts ignored
  // S_SAMPLE | collect NSAMP matches, first mismatch fails the tap
  // S_EVAL   | update run tracker, advance tap or finish lane
  // S_FINAL  | load the window centre, flag lane if nothing passed
  // S_NEXT   | advance lane or finish
  // S_DONE   | one-cycle completion, done held afterwards
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_FINAL, S_NEXT, S_DONE
  } state_t;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int CW = $clog2(NSAMP + 1);

  state_t        state;
  logic [TW-1:0] tap;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] samp_cnt;
  logic          tap_pass;
  logic [TW:0]   cur_len, best_len, nc_len, nb_len, cand_len;
  logic [TW-1:0] cur_start, best_start, nc_start, nb_start, cand_start;
  logic [TW-1:0] centre;
  logic          last_tap, close_run;

  always_comb begin
    last_tap   = (tap == TW'(NTAPS - 1));
    nc_len     = tap_pass ? cur_len + (TW+1)'(1) : '0;
    nc_start   = (tap_pass && cur_len == '0) ? tap : cur_start;
    // a failing tap closes the run before it; the last tap also closes a run still open
    cand_len   = tap_pass ? nc_len : cur_len;
    cand_start = tap_pass ? nc_start : cur_start;
    close_run  = !tap_pass || last_tap;
    nb_len     = best_len;
    nb_start   = best_start;
    if (close_run && cand_len > best_len) begin
      nb_len   = cand_len;
      nb_start = cand_start;
    end
    // start + len/2 never exceeds NTAPS-1, so the TW-bit sum cannot overflow
    centre = nb_start + nb_len[TW:1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tap        <= '0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      tap_pass   <= 1'b0;
      cur_len    <= '0;
      cur_start  <= '0;
      best_len   <= '0;
      best_start <= '0;
      bit_sel    <= '0;
      delay_tap  <= '0;
      delay_load <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail_mask  <= '0;
    end else begin
      delay_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            fail_mask  <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            bit_sel    <= '0;
            tap        <= '0;
            delay_tap  <= '0;
            cur_len    <= '0;
            cur_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
            delay_load <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          settle_cnt <= SW'(SETTLE - 1);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            samp_cnt <= CW'(NSAMP);
            state    <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_SAMPLE: begin
          if (match_valid) begin
            if (!match) begin
              tap_pass <= 1'b0;
              state    <= S_EVAL;
            end else if (samp_cnt == CW'(1)) begin
              tap_pass <= 1'b1;
              state    <= S_EVAL;
            end else begin
              samp_cnt <= samp_cnt - 1'b1;
            end
          end
        end
        S_EVAL: begin
          best_len   <= nb_len;
          best_start <= nb_start;
          cur_len    <= nc_len;
          cur_start  <= nc_start;
          delay_load <= 1'b1;
          if (last_tap) begin
            delay_tap <= (nb_len == '0) ? '0 : centre;
            state     <= S_FINAL;
          end else begin
            tap       <= tap + 1'b1;
            delay_tap <= tap + 1'b1;
            state     <= S_LOAD;
          end
        end
        S_FINAL: begin
          if (best_len == '0) fail_mask[bit_sel] <= 1'b1;
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (bit_sel == 6'(NBITS - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            bit_sel    <= bit_sel + 1'b1;
            tap        <= '0;
            delay_tap  <= '0;
            cur_len    <= '0;
            cur_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
            delay_load <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
